vector_stream_loader: RTL and testbench
=======================================

VECTOR_STREAM_LOADER -- requirements
Module: vector_stream_loader

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset; the ports are named clk and rst.
REQ-002 Parameter BITS, default 8: element and length width.
REQ-003 Parameter N, default 64: maximum vector length in elements; N <= 2**BITS-1 is required.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 s_data  input  BITS (signed)  streamed element.
REQ-007 s_valid  input  1  s_data is valid this cycle.
REQ-008 s_last  input  1  the current element is the final element of the vector.
REQ-009 s_ready  output  1  the loader accepts an element this cycle.
REQ-010 vec_out  output  BITS x N (signed, unpacked [N-1:0])  parallel vector to the reduce ALU input.
REQ-011 vec_len  output  BITS  count of valid elements in vec_out.
REQ-012 set  output  1  one-cycle start pulse to the reduce ALU.
REQ-013 alu_done  input  1  the reduce ALU result is valid.
REQ-014 busy  output  1  high whenever state != FILL.
REQ-015 ovf  output  1  sticky flag: a vector exceeded N elements.
REQ-016 ovf_clr  input  1  clears ovf.

Function
REQ-017 The FSM SHALL have states FILL, DRAIN, ISSUE and WAIT.
REQ-018 Transfer rule: an element transfers on any edge where s_valid && s_ready; s_ready SHALL be 1 in FILL and DRAIN and 0 in ISSUE and WAIT.
REQ-019 FILL: on a transfer, write s_data to vec_out[count] and increment count (width $clog2(N)+1).
REQ-020 FILL with s_last, or with count == N-1: set vec_len = count+1 on the same edge.
REQ-021 FILL, next state: go to ISSUE on s_last; go to DRAIN when count == N-1 without s_last.
REQ-022 DRAIN: transferred elements SHALL be discarded; on a transfer with s_last, set ovf and go to ISSUE.
REQ-023 ISSUE: set = 1 for exactly one cycle, vec_out and vec_len held stable, then go to WAIT.
REQ-024 WAIT: ignore alu_done in the first WAIT cycle; afterwards alu_done = 1 returns the FSM to FILL with count = 0.
REQ-025 vec_out and vec_len SHALL remain stable from ISSUE until the next FILL write; the reduce ALU registers them on set.
REQ-026 Latency: set asserts exactly one cycle after the final transfer; the first element of the next vector is accepted the cycle after alu_done is seen.
REQ-027 ovf: asserting ovf and ovf_clr in the same cycle SHALL leave ovf = 1; ovf is otherwise cleared only by ovf_clr or rst.
REQ-028 The s_valid=0 cycles within a vector SHALL not alter state.

Reset
REQ-029 rst SHALL produce: state FILL, count 0, vec_len 0, all vec_out elements 0, set 0, ovf 0, s_ready 1, busy 0.
REQ-030 rst mid-operation (any state) SHALL take priority over every other event; any pending set is dropped and the partial vector is lost.

Configuration
REQ-031 The macro VEC_LOADER_ZERO_FILL_EN SHALL control zero-filling of the vector buffer.
REQ-032 With VEC_LOADER_ZERO_FILL_EN defined: the first transfer of each vector clears vec_out[1..N-1] to 0 on the same edge as writing element 0.
REQ-033 Without VEC_LOADER_ZERO_FILL_EN: elements at vec_len and above retain stale values from the previous vector.

Structure
REQ-034 Package vec_pkg SHALL hold the default BITS and N constants and the loader_state_t enum (FILL, DRAIN, ISSUE, WAIT).
REQ-035 Sub-module vec_buffer (N x BITS storage with write index, write enable and clear) SHALL be instantiated once; the FSM and counters live in the top level.

Verification (BITS=8, N=4)
REQ-036 Stream 3,-2,7 (last on 7) -> set pulses one cycle after the 7 transfer, vec_len=3, vec_out[0..2]=3,-2,7; returns to FILL after alu_done.
REQ-037 Stream 1,2,3,4,5,6 (last on 6) -> vec_len=4, vec_out=1,2,3,4, elements 5 and 6 discarded in DRAIN, ovf=1, a single set pulse.
REQ-038 s_valid held high in WAIT -> s_ready=0, no writes; alu_done=1 in the first WAIT cycle is ignored, alu_done=1 on a later cycle resumes FILL.
REQ-039 rst asserted in WAIT with vec_len=2 -> next cycle state FILL, vec_len=0, vec_out all 0, set stays 0.
REQ-040 Stream 9,9,9,9 then 5 (last) with ZERO_FILL_EN defined -> vec_out=5,0,0,0; without the macro -> vec_out=5,9,9,9; vec_len=1 in both cases.
REQ-041 ovf=1 set in the same cycle as ovf_clr -> ovf=1; ovf_clr on the next cycle -> ovf=0.

Source files
------------

// File: rtl/vector_stream_loader_pkg.sv
// Shared constants and state encoding for the vector stream loader.
package vec_pkg;

  localparam int unsigned VEC_BITS_DEFAULT = 8;
  localparam int unsigned VEC_N_DEFAULT    = 64;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    DRAIN = 2'd1,
    ISSUE = 2'd2,
    WAIT  = 2'd3
  } loader_state_t;

endpackage

// File: rtl/vector_stream_loader_buffer.sv
// N x BITS element storage: one indexed write port plus a whole-buffer clear.
// A write on the same edge as a clear keeps the written element.
module vec_buffer #(
  parameter int unsigned BITS = 8,
  parameter int unsigned N    = 64,
  parameter int unsigned IW   = 6
) (
  input  logic                   clk,
  input  logic                   clr_i,
  input  logic                   we_i,
  input  logic [IW-1:0]          widx_i,
  input  logic signed [BITS-1:0] wdata_i,
  output logic signed [BITS-1:0] data_o [N-1:0]
);

  logic signed [BITS-1:0] mem_q [N-1:0];

  // Per-element update: indexed write wins over clear.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < N; i++) begin
      if (we_i && (widx_i == IW'(i))) begin
        mem_q[i] <= wdata_i;
      end else if (clr_i) begin
        mem_q[i] <= '0;
      end
    end
  end

  assign data_o = mem_q;

endmodule

// File: rtl/vector_stream_loader.sv
// Streams elements into a parallel vector, then hands it to a reduce ALU.
// Optional macro VEC_LOADER_ZERO_FILL_EN: the first element of each vector
// also clears the rest of the buffer; otherwise stale elements remain.
module vector_stream_loader
  import vec_pkg::*;
#(
  parameter int unsigned BITS = VEC_BITS_DEFAULT,
  parameter int unsigned N    = VEC_N_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic signed [BITS-1:0] s_data,
  input  logic                   s_valid,
  input  logic                   s_last,
  output logic                   s_ready,
  output logic signed [BITS-1:0] vec_out [N-1:0],
  output logic [BITS-1:0]        vec_len,
  output logic                   set,
  input  logic                   alu_done,
  output logic                   busy,
  output logic                   ovf,
  input  logic                   ovf_clr
);

  localparam int unsigned CW = $clog2(N) + 1;
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  loader_state_t   state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [BITS-1:0] len_q, len_d;
  logic            ovf_q, ovf_d;
  logic            wait_first_q, wait_first_d;

  logic            xfer;
  logic            at_top;
  logic            buf_we;
  logic            buf_clr;
  logic [IW-1:0]   buf_idx;

  // Next-state, buffer control and handshake outputs.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    len_d        = len_q;
    wait_first_d = 1'b0;
    ovf_d        = ovf_q & ~ovf_clr;
    s_ready      = (state_q == FILL) || (state_q == DRAIN);
    xfer         = s_valid && s_ready;
    at_top       = (count_q == CW'(N - 1));
    set          = 1'b0;
    buf_we       = 1'b0;
    buf_clr      = rst;
    buf_idx      = count_q[IW-1:0];

    unique case (state_q)
      FILL: begin
        if (xfer) begin
          buf_we  = 1'b1;
`ifdef VEC_LOADER_ZERO_FILL_EN
          if (count_q == '0) begin
            buf_clr = 1'b1;
          end
`endif
          count_d = count_q + CW'(1);
          if (s_last || at_top) begin
            len_d = BITS'(count_q + CW'(1));
          end
          if (s_last) begin
            state_d = ISSUE;
          end else if (at_top) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (xfer && s_last) begin
          ovf_d   = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        set          = 1'b1;
        state_d      = WAIT;
        wait_first_d = 1'b1;
      end
      WAIT: begin
        if (!wait_first_q && alu_done) begin
          state_d = FILL;
          count_d = '0;
        end
      end
      default: state_d = FILL;
    endcase

    // Reset overrides any write or start pulse in the same cycle.
    if (rst) begin
      buf_we = 1'b0;
      set    = 1'b0;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FILL;
      count_q      <= '0;
      len_q        <= '0;
      ovf_q        <= 1'b0;
      wait_first_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      len_q        <= len_d;
      ovf_q        <= ovf_d;
      wait_first_q <= wait_first_d;
    end
  end

  vec_buffer #(
    .BITS (BITS),
    .N    (N),
    .IW   (IW)
  ) u_buffer (
    .clk     (clk),
    .clr_i   (buf_clr),
    .we_i    (buf_we),
    .widx_i  (buf_idx),
    .wdata_i (s_data),
    .data_o  (vec_out)
  );

  assign vec_len = len_q;
  assign busy    = (state_q != FILL);
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_vector_stream_loader.sv
// Directed bench for vector_stream_loader (BITS=8, N=4) with a vector scoreboard.
module tb_vector_stream_loader;

  localparam int unsigned BITS = 8;
  localparam int unsigned N    = 4;

`ifdef VEC_LOADER_ZERO_FILL_EN
  localparam bit ZF = 1'b1;
`else
  localparam bit ZF = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst;
  logic signed [BITS-1:0] s_data;
  logic                   s_valid;
  logic                   s_last;
  logic                   s_ready;
  logic signed [BITS-1:0] vec_out [N-1:0];
  logic [BITS-1:0]        vec_len;
  logic                   set;
  logic                   alu_done;
  logic                   busy;
  logic                   ovf;
  logic                   ovf_clr;

  int n_cmp = 0;
  int n_bad = 0;
  int set_cnt = 0;
  int set_base;

  typedef struct packed {
    logic [7:0]      len;
    logic [3:0][7:0] el;
    logic            ovf;
  } exp_t;

  exp_t sb [$];

  vector_stream_loader #(.BITS(BITS), .N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_last   (s_last),
    .s_ready  (s_ready),
    .vec_out  (vec_out),
    .vec_len  (vec_len),
    .set      (set),
    .alu_done (alu_done),
    .busy     (busy),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (set === 1'b1) set_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    step();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic push(input logic [7:0] len, input logic [7:0] e0, input logic [7:0] e1,
                      input logic [7:0] e2, input logic [7:0] e3, input logic ov);
    exp_t e;
    e.len   = len;
    e.el[0] = e0;
    e.el[1] = e1;
    e.el[2] = e2;
    e.el[3] = e3;
    e.ovf   = ov;
    sb.push_back(e);
  endtask

  task automatic chk_vec(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                         input logic [7:0] e2, input logic [7:0] e3);
    chk({tag, ".v0"}, vec_out[0], e0);
    chk({tag, ".v1"}, vec_out[1], e1);
    chk({tag, ".v2"}, vec_out[2], e2);
    chk({tag, ".v3"}, vec_out[3], e3);
  endtask

  // Called in the cycle after the final transfer: set must be up now.
  task automatic check_issue(input string tag);
    exp_t e;
    chk({tag, ".set"}, 8'(set), 8'd1);
    n_cmp++;
    assert (sb.size() != 0) else begin
      n_bad++;
      $error("FAIL %s.sb: observed empty queue expected entry", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, ".len"}, vec_len, e.len);
      chk_vec(tag, e.el[0], e.el[1], e.el[2], e.el[3]);
      chk({tag, ".ovf"}, 8'(ovf), 8'(e.ovf));
    end
  endtask

  // Called in the first WAIT cycle; alu_done there must be ignored.
  task automatic wait_done(input string tag, input bit hold, input logic [7:0] v0);
    chk({tag, ".w_set"}, 8'(set), 8'd0);
    chk({tag, ".w_busy"}, 8'(busy), 8'd1);
    chk({tag, ".w_rdy"}, 8'(s_ready), 8'd0);
    alu_done = 1'b1;
    if (hold) begin
      s_valid = 1'b1;
      s_data  = 8'h63;
    end
    step();
    chk({tag, ".ign_busy"}, 8'(busy), 8'd1);
    chk({tag, ".ign_rdy"}, 8'(s_ready), 8'd0);
    s_valid = 1'b0;
    step();
    alu_done = 1'b0;
    chk({tag, ".d_busy"}, 8'(busy), 8'd0);
    chk({tag, ".d_rdy"}, 8'(s_ready), 8'd1);
    chk({tag, ".d_v0"}, vec_out[0], v0);
  endtask

  initial begin
    rst      = 1'b1;
    s_data   = '0;
    s_valid  = 1'b0;
    s_last   = 1'b0;
    alu_done = 1'b0;
    ovf_clr  = 1'b0;
    step();
    step();
    rst = 1'b0;

    // Reset state
    chk("rst.len", vec_len, 8'd0);
    chk_vec("rst", 8'd0, 8'd0, 8'd0, 8'd0);
    chk("rst.set", 8'(set), 8'd0);
    chk("rst.ovf", 8'(ovf), 8'd0);
    chk("rst.rdy", 8'(s_ready), 8'd1);
    chk("rst.busy", 8'(busy), 8'd0);

    // A: 3,-2,7
    push(8'd3, 8'd3, 8'hFE, 8'd7, 8'd0, 1'b0);
    send(8'd3, 1'b0);
    send(8'hFE, 1'b0);
    chk("A.fill_busy", 8'(busy), 8'd0);
    send(8'd7, 1'b1);
    check_issue("A");
    step();
    wait_done("A", 1'b0, 8'd3);

    // B: 1..6 with an idle gap, overflow into DRAIN, s_valid held in WAIT
    set_base = set_cnt;
    push(8'd4, 8'd1, 8'd2, 8'd3, 8'd4, 1'b1);
    send(8'd1, 1'b0);
    send(8'd2, 1'b0);
    step();
    chk("B.gap_busy", 8'(busy), 8'd0);
    send(8'd3, 1'b0);
    send(8'd4, 1'b0);
    chk("B.drain_busy", 8'(busy), 8'd1);
    chk("B.drain_rdy", 8'(s_ready), 8'd1);
    chk("B.drain_set", 8'(set), 8'd0);
    chk("B.drain_len", vec_len, 8'd4);
    chk("B.drain_ovf", 8'(ovf), 8'd0);
    send(8'd5, 1'b0);
    send(8'd6, 1'b1);
    check_issue("B");
    step();
    wait_done("B", 1'b1, 8'd1);
    chk("B.len_hold", vec_len, 8'd4);
    chk("B.set_cnt", 8'(set_cnt - set_base), 8'd1);

    // Clear ovf, then set and clear it on the same edge
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("clr.ovf", 8'(ovf), 8'd0);
    push(8'd4, 8'd10, 8'd11, 8'd12, 8'd13, 1'b1);
    send(8'd10, 1'b0);
    send(8'd11, 1'b0);
    send(8'd12, 1'b0);
    send(8'd13, 1'b0);
    ovf_clr = 1'b1;
    send(8'd14, 1'b1);
    check_issue("C");
    step();
    ovf_clr = 1'b0;
    chk("C.ovf_clr", 8'(ovf), 8'd0);
    wait_done("C", 1'b0, 8'd10);

    // D: reset while in WAIT
    push(8'd2, 8'd20, 8'd21, ZF ? 8'd0 : 8'd12, ZF ? 8'd0 : 8'd13, 1'b0);
    send(8'd20, 1'b0);
    send(8'd21, 1'b1);
    check_issue("D");
    step();
    chk("D.wait_busy", 8'(busy), 8'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("D.rst_busy", 8'(busy), 8'd0);
    chk("D.rst_len", vec_len, 8'd0);
    chk_vec("D.rst", 8'd0, 8'd0, 8'd0, 8'd0);
    chk("D.rst_set", 8'(set), 8'd0);
    step();
    chk("D.rst_set2", 8'(set), 8'd0);

    // Reset on the same edge as a final transfer drops the start pulse
    rst = 1'b1;
    send(8'd30, 1'b1);
    rst = 1'b0;
    chk("R.set", 8'(set), 8'd0);
    chk("R.busy", 8'(busy), 8'd0);
    chk("R.len", vec_len, 8'd0);
    chk("R.v0", vec_out[0], 8'd0);

    // E: exactly N elements with last on the final one, no overflow
    push(8'd4, 8'd9, 8'd9, 8'd9, 8'd9, 1'b0);
    send(8'd9, 1'b0);
    send(8'd9, 1'b0);
    send(8'd9, 1'b0);
    send(8'd9, 1'b1);
    check_issue("E");
    step();
    wait_done("E", 1'b0, 8'd9);

    // F: single element, stale or zero-filled tail
    push(8'd1, 8'd5, ZF ? 8'd0 : 8'd9, ZF ? 8'd0 : 8'd9, ZF ? 8'd0 : 8'd9, 1'b0);
    send(8'd5, 1'b1);
    check_issue("F");
    step();
    wait_done("F", 1'b0, 8'd5);

    chk("sb.empty", 8'(sb.size()), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
